// File: rtl/model_scalar_integer_sequential_multiplier.sv
// Iterative shift-add integer multiplier with signed/unsigned mode.
// One operand-width adder, DATA_SIZE+1 cycles from START to the READY pulse.
module model_scalar_integer_sequential_multiplier #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SIGNED_MODE,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic                 READY,
  output logic                 BUSY,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic [DATA_SIZE-1:0] DATA_HIGH_OUT,
  output logic                 OVERFLOW_OUT
);

  localparam int N  = DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_SIZE - 1);

  // CONTROL_SIZE only keeps the library's operators interchangeable.
  if (DATA_SIZE < 2 || CONTROL_SIZE < 1) begin : g_param_check
    $error("model_scalar_integer_sequential_multiplier: bad DATA_SIZE or CONTROL_SIZE");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q;
  logic             mode_q;
  logic             sign_q;
  logic [N-1:0]     mcand_q;
  logic [N-1:0]     mplier_q;
  logic [2*N-1:0]   acc_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic [N-1:0]     lo_q;
  logic [N-1:0]     hi_q;
  logic             ovf_q;

  logic [N-1:0]     mag_a_d;
  logic [N-1:0]     mag_b_d;
  logic             sign_d;
  logic [N:0]       sum_d;
  logic [2*N-1:0]   acc_d;
  logic [2*N-1:0]   prod_d;
  logic             ovf_d;

  always_comb begin
    mag_a_d = (SIGNED_MODE && DATA_A_IN[N-1]) ? -DATA_A_IN : DATA_A_IN;
    mag_b_d = (SIGNED_MODE && DATA_B_IN[N-1]) ? -DATA_B_IN : DATA_B_IN;
    sign_d  = SIGNED_MODE & (DATA_A_IN[N-1] ^ DATA_B_IN[N-1]);
    // Add into the upper half with carry, then shift the whole accumulator right.
    sum_d   = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d   = {sum_d, acc_q[N-1:1]};
    prod_d  = sign_q ? -acc_q : acc_q;
    if (mode_q) begin
      ovf_d = !((&prod_d[2*N-1:N-1]) || !(|prod_d[2*N-1:N-1]));
    end else begin
      ovf_d = |prod_d[2*N-1:N];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            mode_q   <= SIGNED_MODE;
            sign_q   <= sign_d;
            mcand_q  <= mag_a_d;
            mplier_q <= mag_b_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          lo_q    <= prod_d[N-1:0];
          hi_q    <= prod_d[2*N-1:N];
          ovf_q   <= ovf_d;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign READY         = ready_q;
  assign BUSY          = busy_q;
  assign DATA_OUT      = lo_q;
  assign DATA_HIGH_OUT = hi_q;
  assign OVERFLOW_OUT  = ovf_q;

endmodule
